config_chain_ctrl: RTL and testbench
====================================

// Module: config_chain_ctrl
// PURPOSE
//  Next-generation serial configuration loader between the uC SPI-like link (SEL/SDI/SDO) and the chip config nets.
//  Supports framed writes with an opcode header: full write, dynamic-only write, and readback of latched contents.
//  Checks frame length and commits shadow data atomically, so partial or over-long frames never disturb live config.
//  Also decodes the analog-mux select to one-hot.
// PARAMETERS
//  STAT_W  88  static config width
//  DYN_W   16  dynamic config width
//  ADDR_W   7  analog-mux address width; AMUXSEL is 2**ADDR_W wide
// PORTS
//  CLK        in   1            system clock (uC-supplied); all logic on rising edge
//  RST_N      in   1            asynchronous active-low reset
//  SEL        in   1            frame strobe; high = frame active
//  SDI        in   1            serial data in, MSB first, sampled on rising CLK while SEL=1
//  SDO        out  1            serial data out (chain pass-through / readback)
//  STATCNF    out  STAT_W       latched static config
//  DYNCNF     out  DYN_W        latched dynamic config
//  AMUXSEL    out  2**ADDR_W    one-hot decode of latched address; all-zero until first valid full write
//  LOAD_OK    out  1            1-cycle pulse: frame committed / readback completed
//  FRAME_ERR  out  1            1-cycle pulse: frame rejected
// BEHAVIOUR
//  Reset: all outputs, shadow regs, counter, addr_valid = 0; state IDLE. Reset mid-frame aborts the frame, nothing commits.
//  Frame: bits 1..2 = opcode OP[1:0] (MSB first); payload follows.
//   OP=00 FULL: payload {STAT,DYN,ADDR} MSB first; exact length FULL_W = STAT_W+DYN_W+ADDR_W (111 default).
//   OP=01 DYN : payload DYN only; exact length DYN_W. STATCNF/AMUXSEL untouched.
//   OP=10 READ: no payload required; SDO shifts out latched {STATCNF,DYNCNF,addr}, MSB first.
//   OP=11: reserved -> FRAME_ERR at frame end.
//  FSM: IDLE -(SEL=1, capture SDI as OP[1])-> OPCODE -(capture OP[0])-> WDATA (OP=00/01) or RDATA (OP=10/11).
//   Any state except IDLE -(SEL sampled 0)-> EVAL (evaluated on that same edge) -> IDLE.
//  Payload counter: width clog2(FULL_W+2), counts payload bits only, saturates at FULL_W+1.
//  Write: shadow shift reg (FULL_W bits) shifts left, SDI enters LSB.
//   On the SEL-low edge, if count == required length: FULL -> STATCNF/DYNCNF/addr <= shadow, addr_valid <= 1;
//   DYN -> DYNCNF <= shadow[DYN_W-1:0]. Outputs change on that edge; LOAD_OK high for the following cycle.
//   Count short, long, or SEL dropped during the opcode -> no output change, FRAME_ERR high for the following cycle.
//  Read: on the edge leaving OPCODE, readback reg <= latched {STATCNF,DYNCNF,addr}, then shifts 1 bit per cycle, zero fill.
//   Frame end: LOAD_OK if count >= FULL_W, else neither pulse (early abort allowed). Latched config never changes.
//  SDO: IDLE/OPCODE = 0; WDATA = shadow MSB (daisy chain, delay = FULL_W cycles); RDATA = readback MSB (registered).
//  AMUXSEL = addr_valid ? (1 << addr) : 0; combinational from registers.
//  SEL high for one cycle only: frame ends in OPCODE -> FRAME_ERR. LOAD_OK and FRAME_ERR are never both high.
//  A new frame may start on the cycle after EVAL (one idle cycle minimum between frames).
// TESTING
//  1 Reset, no frames -> STATCNF=0, DYNCNF=0, AMUXSEL=0, SDO=0, no pulses.
//  2 FULL frame, 113 SEL-high cycles: OP=00, STAT=88'hA5..A5, DYN=16'hBEEF, ADDR=7'd5 -> outputs latched, AMUXSEL=1<<5, one LOAD_OK.
//  3 FULL frame with 110 payload bits, then 112 -> both FRAME_ERR, outputs keep test-2 values.
//  4 DYN frame OP=01 + 16'h1234 -> DYNCNF=16'h1234; STATCNF, AMUXSEL unchanged; LOAD_OK.
//  5 READ frame OP=10 + 111 cycles -> SDO stream equals {STATCNF,DYNCNF,7'd5}; LOAD_OK; config unchanged.
//  6 RST_N low at payload bit 50 of a FULL frame -> all outputs 0, no pulses; next valid frame loads normally.

Source files
------------

// File: rtl/config_chain_ctrl_if.sv
// Serial config link and latched config outputs for config_chain_ctrl.
// The uC side drives SEL/SDI; the loader drives everything else.
interface config_chain_ctrl_if #(
  parameter int STAT_W = 88,
  parameter int DYN_W  = 16,
  parameter int ADDR_W = 7
);
  logic                 SEL;
  logic                 SDI;
  logic                 SDO;
  logic [STAT_W-1:0]    STATCNF;
  logic [DYN_W-1:0]     DYNCNF;
  logic [2**ADDR_W-1:0] AMUXSEL;
  logic                 LOAD_OK;
  logic                 FRAME_ERR;

  modport master (
    output SEL, SDI,
    input  SDO, STATCNF, DYNCNF, AMUXSEL, LOAD_OK, FRAME_ERR
  );

  modport slave (
    input  SEL, SDI,
    output SDO, STATCNF, DYNCNF, AMUXSEL, LOAD_OK, FRAME_ERR
  );
endinterface

// File: rtl/config_chain_ctrl.sv
// Framed serial configuration loader: opcode header, shadow shift register with
// atomic length-checked commit, readback shifter and one-hot analog-mux decode.
module config_chain_ctrl #(
  parameter int STAT_W = 88,
  parameter int DYN_W  = 16,
  parameter int ADDR_W = 7
) (
  input logic              CLK,
  input logic              RST_N,
  config_chain_ctrl_if.slave bus
);
  localparam int FULL_W = STAT_W + DYN_W + ADDR_W;
  localparam int CNT_W  = $clog2(FULL_W + 2);
  localparam int AMUX_W = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FULL_W);
  localparam logic [CNT_W-1:0] CNT_DYN  = CNT_W'(DYN_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FULL_W + 1);

  typedef enum logic [2:0] {IDLE, OPCODE, WDATA, RDATA, EVAL} state_t;

  state_t              state, state_nxt;
  logic [1:0]          op;
  logic [CNT_W-1:0]    cnt;
  logic [FULL_W-1:0]   shadow;
  logic [FULL_W-1:0]   readback;
  logic [STAT_W-1:0]   stat_q;
  logic [DYN_W-1:0]    dyn_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                addr_valid;
  logic                load_ok;
  logic                frame_err;
  logic                sdo;
  logic [AMUX_W-1:0]   amux;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // op[1] is already held while in OPCODE; SDI on this edge is op[0]
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.SEL) state_nxt = OPCODE;
      OPCODE:  if (!bus.SEL)    state_nxt = EVAL;
               else if (op[1])  state_nxt = RDATA;
               else             state_nxt = WDATA;
      WDATA,
      RDATA:   if (!bus.SEL) state_nxt = EVAL;
      EVAL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op         <= '0;
      cnt        <= '0;
      shadow     <= '0;
      readback   <= '0;
      stat_q     <= '0;
      dyn_q      <= '0;
      addr_q     <= '0;
      addr_valid <= 1'b0;
      load_ok    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      load_ok   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (bus.SEL) begin
          op  <= {bus.SDI, 1'b0};
          cnt <= '0;
        end
        OPCODE: begin
          if (bus.SEL) begin
            op[0] <= bus.SDI;
            if (op[1]) readback <= {stat_q, dyn_q, addr_q};
          end else begin
            frame_err <= 1'b1;
          end
        end
        WDATA: begin
          if (bus.SEL) begin
            shadow <= {shadow[FULL_W-2:0], bus.SDI};
            cnt    <= sat_inc(cnt);
          end else if (!op[0] && cnt == CNT_FULL) begin
            {stat_q, dyn_q, addr_q} <= shadow;
            addr_valid <= 1'b1;
            load_ok    <= 1'b1;
          end else if (op[0] && cnt == CNT_DYN) begin
            dyn_q   <= shadow[DYN_W-1:0];
            load_ok <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        RDATA: begin
          if (bus.SEL) begin
            readback <= {readback[FULL_W-2:0], 1'b0};
            cnt      <= sat_inc(cnt);
          end else if (op[0]) begin
            frame_err <= 1'b1;
          end else if (cnt >= CNT_FULL) begin
            load_ok <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sdo = 1'b0;
    case (state)
      WDATA:   sdo = shadow[FULL_W-1];
      RDATA:   sdo = readback[FULL_W-1];
      default: sdo = 1'b0;
    endcase
  end

  always_comb begin
    amux = '0;
    if (addr_valid) amux[addr_q] = 1'b1;
  end

  assign bus.SDO       = sdo;
  assign bus.STATCNF   = stat_q;
  assign bus.DYNCNF    = dyn_q;
  assign bus.AMUXSEL   = amux;
  assign bus.LOAD_OK   = load_ok;
  assign bus.FRAME_ERR = frame_err;
endmodule

// File: tb/tb_config_chain_ctrl.sv
// Bench for config_chain_ctrl: directed frames plus random frames checked
// against a frame-level model of the latched config, SDO stream and pulses.
module tb_config_chain_ctrl;
  localparam int STAT_W = 88;
  localparam int DYN_W  = 16;
  localparam int ADDR_W = 7;
  localparam int FULL_W = STAT_W + DYN_W + ADDR_W;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  config_chain_ctrl_if #(.STAT_W(STAT_W), .DYN_W(DYN_W), .ADDR_W(ADDR_W)) bus ();
  config_chain_ctrl #(.STAT_W(STAT_W), .DYN_W(DYN_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [STAT_W-1:0] m_stat;
  logic [DYN_W-1:0]  m_dyn;
  logic [ADDR_W-1:0] m_addr;
  bit                m_valid;
  bit                hist[$];
  bit                fb[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_stat = '0; m_dyn = '0; m_addr = '0; m_valid = 1'b0;
    hist.delete();
  endtask

  task automatic check_latched(input string tag);
    chk({tag, "_stat"}, bus.STATCNF, m_stat);
    chk({tag, "_dyn"},  bus.DYNCNF,  m_dyn);
    chk({tag, "_amux"}, bus.AMUXSEL, m_valid ? (128'd1 << m_addr) : 128'd0);
  endtask

  // Payload bit i is word[FULL_W-1-i]; bits past FULL_W are ones.
  task automatic build(input logic [1:0] op, input logic [FULL_W-1:0] word, input int len);
    fb.delete();
    fb.push_back(op[1]);
    fb.push_back(op[0]);
    for (int i = 0; i < len; i++) fb.push_back((i < FULL_W) ? word[FULL_W-1-i] : 1'b1);
  endtask

  task automatic run_frame(input string tag, input int abort_at);
    int               len, sz, bad_sdo, bad_pulse;
    logic [1:0]       op;
    bit               exp_ok, exp_err, aborted, e;
    logic [FULL_W-1:0] rb, w;
    sz  = fb.size();
    len = sz - 2;
    op  = (sz >= 2) ? {fb[0], fb[1]} : 2'b00;
    rb  = {m_stat, m_dyn, m_addr};
    exp_ok = 1'b0; exp_err = 1'b0;
    if (sz < 2) exp_err = 1'b1;
    else case (op)
      2'b00: if (len == FULL_W) exp_ok = 1'b1; else exp_err = 1'b1;
      2'b01: if (len == DYN_W)  exp_ok = 1'b1; else exp_err = 1'b1;
      2'b10: exp_ok = (len >= FULL_W);
      default: exp_err = 1'b1;
    endcase
    bad_sdo = 0; bad_pulse = 0; aborted = 1'b0;
    for (int k = 0; k <= sz; k++) begin
      @(negedge CLK);
      if (k == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (k < 2 || sz < 2)  e = 1'b0;
      else if (op[1])       e = (k - 2 < FULL_W) ? rb[FULL_W-1-(k-2)] : 1'b0;
      else                  e = (hist.size() == FULL_W) ? hist[0] : 1'b0;
      if (bus.SDO !== e) bad_sdo++;
      if (bus.LOAD_OK !== 1'b0 || bus.FRAME_ERR !== 1'b0) bad_pulse++;
      if (k < sz) begin
        bus.SEL = 1'b1;
        bus.SDI = fb[k];
        if (k >= 2 && !op[1]) begin
          hist.push_back(fb[k]);
          if (hist.size() > FULL_W) void'(hist.pop_front());
        end
      end else begin
        bus.SEL = 1'b0;
        bus.SDI = 1'b0;
      end
    end
    chk({tag, "_sdo_errs"},   bad_sdo,   0);
    chk({tag, "_pulse_errs"}, bad_pulse, 0);
    if (aborted) begin
      #1 RST_N = 1'b0;
      bus.SEL = 1'b0;
      model_reset();
      #1;
      check_latched({tag, "_rst"});
      chk({tag, "_rst_sdo"},   bus.SDO, 1'b0);
      chk({tag, "_rst_pulse"}, {bus.LOAD_OK, bus.FRAME_ERR}, 2'b00);
      @(negedge CLK) RST_N = 1'b1;
      @(negedge CLK);
      chk({tag, "_post_rst_pulse"}, {bus.LOAD_OK, bus.FRAME_ERR}, 2'b00);
      return;
    end
    if (exp_ok && op == 2'b00) begin
      w = '0;
      for (int i = 0; i < FULL_W; i++) w = {w[FULL_W-2:0], fb[i+2]};
      {m_stat, m_dyn, m_addr} = w;
      m_valid = 1'b1;
    end else if (exp_ok && op == 2'b01) begin
      for (int i = 0; i < DYN_W; i++) m_dyn = {m_dyn[DYN_W-2:0], fb[i+2]};
    end
    @(negedge CLK);
    chk({tag, "_load_ok"},   bus.LOAD_OK,   exp_ok);
    chk({tag, "_frame_err"}, bus.FRAME_ERR, exp_err);
    check_latched(tag);
    @(negedge CLK);
    chk({tag, "_pulse_clr"}, {bus.LOAD_OK, bus.FRAME_ERR}, 2'b00);
  endtask

  initial begin
    logic [127:0]      r;
    logic [1:0]        op;
    int                len, pick;
    logic [FULL_W-1:0] w2;

    RST_N   = 1'b0;
    bus.SEL = 1'b0;
    bus.SDI = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    check_latched("reset");
    chk("reset_sdo",   bus.SDO, 1'b0);
    chk("reset_pulse", {bus.LOAD_OK, bus.FRAME_ERR}, 2'b00);

    w2 = {{11{8'hA5}}, 16'hBEEF, 7'd5};
    build(2'b00, w2, FULL_W);        run_frame("full", -1);
    build(2'b00, ~w2, FULL_W - 1);   run_frame("full_short", -1);
    build(2'b00, ~w2, FULL_W + 1);   run_frame("full_long", -1);
    build(2'b01, {16'h1234, 95'd0}, DYN_W); run_frame("dyn", -1);
    build(2'b10, '0, FULL_W);        run_frame("read", -1);
    build(2'b11, '0, 4);             run_frame("reserved", -1);
    fb.delete(); fb.push_back(1'b0); run_frame("one_cycle", -1);
    build(2'b00, ~w2, FULL_W);       run_frame("rst_mid", 2 + 50);
    build(2'b00, {{11{8'h3C}}, 16'h0F0F, 7'd127}, FULL_W); run_frame("after_rst", -1);

    for (int n = 0; n < 24; n++) begin
      r  = {$urandom, $urandom, $urandom, $urandom};
      op = 2'($urandom_range(0, 3));
      pick = $urandom_range(0, 3);
      case (op)
        2'b00: len = (pick < 2) ? FULL_W : (pick == 2 ? FULL_W - 1 : FULL_W + 1);
        2'b01: len = (pick < 2) ? DYN_W : (pick == 2 ? DYN_W - 1 : DYN_W + 1);
        2'b10: len = (pick < 2) ? FULL_W : (pick == 2 ? 30 : FULL_W + 3);
        default: len = pick;
      endcase
      if (op == 2'b01) build(op, {r[15:0], 95'd0}, len);
      else             build(op, r[FULL_W-1:0], len);
      run_frame($sformatf("rnd%0d", n), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
